// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage load/store unit: access sizes,
// response error codes, FSM states and the byte-lane enable mapping.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Big-endian lanes: offset 0 is be[3] / bits [31:24].
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b1000 >> off;
      SZ_HALF: return off[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [1:0] check_req(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'b11)                        return ERR_ILLEGAL;
    else if (size == SZ_HALF && off[0])       return ERR_MISALIGN;
    else if (size == SZ_WORD && off != 2'b00) return ERR_MISALIGN;
    else                                      return ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_data_extend.sv
// Picks the addressed byte/half out of a big-endian 32-bit read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_data_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[31:24];
      2'd1:    byte_sel = rdata_i[23:16];
      2'd2:    byte_sel = rdata_i[15:8];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: lane-aligns stores, runs one req/ack bus
// transaction with a timeout, and returns extended load data or an error.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_err_q, rsp_err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  sgn_q, sgn_d;

  logic                  accept, ack_hit, to_hit;
  logic [1:0]            chk_err;
  logic [DATA_WIDTH-1:0] st_data, ld_data;

  assign accept  = req_valid && req_ready_q && (state_q == ST_IDLE);
  assign chk_err = check_req(req_size, req_addr[1:0]);
  assign ack_hit = (state_q == ST_ACCESS) && mem_ack;
  // Ack on the final allowed cycle takes priority over the timeout.
  assign to_hit  = (state_q == ST_ACCESS) && !mem_ack &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    case (req_size)
      SZ_BYTE: st_data = {4{req_wdata[7:0]}};
      SZ_HALF: st_data = {2{req_wdata[15:0]}};
      default: st_data = req_wdata;
    endcase
  end

  load_data_extend u_ext (
    .rdata_i  (mem_rdata),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_NONE;
      cnt_q       <= '0;
      size_q      <= SZ_BYTE;
      off_q       <= '0;
      sgn_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sgn_q       <= sgn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (chk_err != ERR_NONE) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (ack_hit || to_hit) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    off_d       = off_q;
    sgn_d       = sgn_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        req_ready_d = 1'b0;
        cnt_d       = '0;
        size_d      = req_size;
        off_d       = req_addr[1:0];
        sgn_d       = req_signed;
        if (chk_err != ERR_NONE) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = chk_err;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_be_d    = lane_be(req_size, req_addr[1:0]);
          mem_wdata_d = req_we ? st_data : '0;
        end
      end
      ST_ACCESS: begin
        if (ack_hit || to_hit) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (ack_hit && !mem_we_q) ? ld_data : '0;
          rsp_err_d   = ack_hit ? ERR_NONE : ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = ERR_NONE;
        req_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready = req_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store engine; the store-side counterpart of the decode-stage sign extender. Takes load/store requests from the execute stage and narrows/aligns store data onto byte lanes with byte enables. Runs a req/ack transaction on the data-memory bus, then extracts and sign- or zero-extends load data back to 32 bits. Big-endian: byte offset 0 maps to bits [31:24].

Parameters:
DATA_WIDTH, 32, data path width; only 32 is supported.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 16, cycles without mem_ack before a bus-timeout abort (>=2).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-justified
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0)
mem_be  out  4  byte enables; bit3 = bits[31:24]
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_ack  in  1  bus completes the transaction this cycle
mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
rsp_err  out  2  00 ok, 01 misaligned, 10 illegal size, 11 bus timeout

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All outputs are registered. Reset forces IDLE, req_ready=1, and mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err all 0.
- req_ready=1 only in IDLE. A request is accepted when req_valid&&req_ready.
- Check on accept:
  - size=11 gives err 10.
  - half with addr[0]=1, or word with addr[1:0]!=0, gives err 01.
  - Either error goes straight to RESP with no bus access.
- Lane mapping, with offset o=addr[1:0]:
  - byte: be = 4'b1000>>o; wdata = {4{wdata[7:0]}}.
  - half: be = 4'b1100 (o=0) or 4'b0011 (o=2); wdata = {2{wdata[15:0]}}.
  - word: be = 4'b1111; wdata unchanged.
  - Loads drive the same be values.
- Valid accept at cycle T moves to ACCESS. mem_req=1 from T+1 and is held, with addr/be/we/wdata stable, until the cycle mem_ack=1 is sampled. mem_req drops the next cycle.
- A load on mem_ack selects the lane byte/half from mem_rdata and extends it per req_signed; the result is latched into rsp_rdata.
- Timeout counter:
  - Clears on accept and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, drop mem_req and go to RESP with err 11.
  - An ack on the timeout cycle wins; the result is ok.
- RESP: rsp_valid=1, held with data/err stable until rsp_ready. On the handshake, return to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Latency: accept T, mem_ack at T+1 gives rsp_valid at T+2. Error paths give rsp_valid at T+1.
- No request is accepted in the cycle RESP completes; the next accept is possible one cycle later in IDLE.
- A mem_ack outside ACCESS is ignored.
- rst asserted mid-transaction aborts immediately: mem_req drops asynchronously and the FSM returns to IDLE. The bus must tolerate an abandoned request.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - error codes ERR_NONE/MISALIGN/ILLEGAL/TIMEOUT.
  - FSM state encoding.
- One natural sub-module: load_data_extend. Purely combinational: mem_rdata, offset, size and signed in, 32-bit extended result out. Reusable by any future load path.

Test Plan:
- Store byte 0xAB at 0x1001, ack on first mem_req cycle -> mem_addr 0x1000, be 0100, wdata 0xABABABAB, mem_we=1; rsp_valid at T+2, err 00, rdata 0.
- Signed half load at 0x2002, mem_rdata 0x12348001 -> rsp_rdata 0xFFFF8001. Same request unsigned -> 0x00008001.
- Byte load at 0x3003, mem_rdata 0x000000F0: signed -> 0xFFFFFFF0; unsigned -> 0x000000F0; be 0001.
- Word load at 0x4002, then size=11 at 0x4000 -> err 01 then err 10, each rsp_valid at T+1, mem_req never asserted.
- Word store, mem_ack withheld, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then err 11.
- rsp_ready held low 5 cycles -> rsp_valid/data stable and req_ready=0 throughout. rst pulsed mid-ACCESS -> mem_req 0 the same cycle, req_ready=1 after release, and the next load completes normally.
